issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 124 ++++++++++++
 tb/tb_issue_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks pending register writes, stalls hazardous bundles,
// and forwards accepted bundles to the register file one cycle later.
module issue_scoreboard #(
  parameter int unsigned NFU = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bundleValid,
  output logic             bundleReady,
  input  logic [NFU-1:0]   slotValid,
  input  logic [NFU-1:0]   slotWe,
  input  logic [NFU*5-1:0] slotDest,
  input  logic [NFU*5-1:0] slotSrc1,
  input  logic [NFU*5-1:0] slotSrc2,
  input  logic [NFU*5-1:0] slotSrc3,
  input  logic             flush,
  input  logic [NFU-1:0]   wbValid,
  input  logic [NFU*5-1:0] wbAddr,
  output logic [NFU-1:0]   enable,
  output logic [NFU*5-1:0] address1,
  output logic [NFU*5-1:0] address2,
  output logic [NFU*5-1:0] address3,
  output logic [NFU-1:0]   issueWe,
  output logic [NFU*5-1:0] issueDest,
  output logic             bundleError,
  output logic             stalled,
  output logic [31:0]      busy,
  output logic [15:0]      stallCount
);

  localparam int unsigned RW = 5;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t      state, stateNext;
  logic        hazard;
  logic        dupDest;
  logic        accept;
  logic        issue;
  logic        stallInc;
  logic [31:0] setMask;
  logic [31:0] clrMask;

  // Hazards look only at registered busy, so same-bundle sources see pre-bundle state.
  always_comb begin
    hazard  = 1'b0;
    dupDest = 1'b0;
    for (int i = 0; i < int'(NFU); i++) begin
      if (slotValid[i]) begin
        if (busy[slotSrc1[i*RW +: RW]] || busy[slotSrc2[i*RW +: RW]] ||
            busy[slotSrc3[i*RW +: RW]])
          hazard = 1'b1;
        if (slotWe[i] && busy[slotDest[i*RW +: RW]])
          hazard = 1'b1;
      end
      for (int j = i + 1; j < int'(NFU); j++) begin
        if (slotValid[i] && slotWe[i] && slotValid[j] && slotWe[j] &&
            (slotDest[i*RW +: RW] == slotDest[j*RW +: RW]))
          dupDest = 1'b1;
      end
    end
  end

  assign bundleReady = !hazard && !flush;
  assign accept      = bundleValid && bundleReady;
  assign issue       = accept && !dupDest;
  assign stallInc    = bundleValid && hazard && !flush;

  // Busy update masks; set is applied after clear so it wins on collisions.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    for (int i = 0; i < int'(NFU); i++) begin
      if (issue && slotValid[i] && slotWe[i])
        setMask[slotDest[i*RW +: RW]] = 1'b1;
      if (wbValid[i])
        clrMask[wbAddr[i*RW +: RW]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (stallInc)  stateNext = STALL;
      STALL:   if (!stallInc) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  assign stalled = (state == STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      stallCount  <= '0;
      enable      <= '0;
      issueWe     <= '0;
      issueDest   <= '0;
      address1    <= '0;
      address2    <= '0;
      address3    <= '0;
      bundleError <= 1'b0;
    end else begin
      busy        <= flush ? 32'h0 : ((busy & ~clrMask) | setMask);
      bundleError <= accept && dupDest;
      enable      <= issue ? slotValid : '0;
      if (stallInc && (stallCount != 16'hFFFF))
        stallCount <= stallCount + 16'd1;
      if (issue) begin
        issueWe   <= slotWe;
        issueDest <= slotDest;
        address1  <= slotSrc1;
        address2  <= slotSrc2;
        address3  <= slotSrc3;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard (NFU = 2).
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bundleValid;
  logic        bundleReady;
  logic [1:0]  slotValid, slotWe;
  logic [9:0]  slotDest, slotSrc1, slotSrc2, slotSrc3;
  logic        flush;
  logic [1:0]  wbValid;
  logic [9:0]  wbAddr;
  logic [1:0]  enable, issueWe;
  logic [9:0]  address1, address2, address3, issueDest;
  logic        bundleError, stalled;
  logic [31:0] busy;
  logic [15:0] stallCount;

  int tests = 0;
  int fails = 0;

  issue_scoreboard #(.NFU(2)) dut (
    .clk(clk), .rst_n(rst_n), .bundleValid(bundleValid), .bundleReady(bundleReady),
    .slotValid(slotValid), .slotWe(slotWe), .slotDest(slotDest),
    .slotSrc1(slotSrc1), .slotSrc2(slotSrc2), .slotSrc3(slotSrc3),
    .flush(flush), .wbValid(wbValid), .wbAddr(wbAddr), .enable(enable),
    .address1(address1), .address2(address2), .address3(address3),
    .issueWe(issueWe), .issueDest(issueDest), .bundleError(bundleError),
    .stalled(stalled), .busy(busy), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    bundleValid = 1'b0; slotValid = '0; slotWe = '0; slotDest = '0;
    slotSrc1 = '0; slotSrc2 = '0; slotSrc3 = '0; flush = 1'b0;
    wbValid = '0; wbAddr = '0;
  endtask

  task automatic setSlot(input int i, input logic v, input logic we, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
    slotValid[i] = v; slotWe[i] = we; slotDest[i*5 +: 5] = d;
    slotSrc1[i*5 +: 5] = s1; slotSrc2[i*5 +: 5] = s2; slotSrc3[i*5 +: 5] = s3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearIn();
    #3;
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h exp=0", busy); end
    tests++; if (enable !== 2'b00) begin fails++; $display("FAIL reset_enable got=%b exp=00", enable); end
    tests++; if (stalled !== 1'b0) begin fails++; $display("FAIL reset_stalled got=%b exp=0", stalled); end
    tests++; if (stallCount !== 16'h0) begin fails++; $display("FAIL reset_count got=%h exp=0", stallCount); end
    tests++; if (bundleError !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", bundleError); end
    tests++; if (issueDest !== 10'h0) begin fails++; $display("FAIL reset_dest got=%h exp=0", issueDest); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_independent();
    bundleValid = 1'b1;
    setSlot(0, 1'b1, 1'b1, 5'd5, 5'd1, 5'd2, 5'd3);
    setSlot(1, 1'b1, 1'b1, 5'd6, 5'd1, 5'd2, 5'd3);
    #1;
    tests++; if (bundleReady !== 1'b1) begin fails++; $display("FAIL ind_ready got=%b exp=1", bundleReady); end
    tick();
    clearIn();
    tests++; if (enable !== 2'b11) begin fails++; $display("FAIL ind_enable got=%b exp=11", enable); end
    tests++; if (issueDest !== {5'd6, 5'd5}) begin fails++; $display("FAIL ind_dest got=%h exp=%h", issueDest, {5'd6, 5'd5}); end
    tests++; if (issueWe !== 2'b11) begin fails++; $display("FAIL ind_we got=%b exp=11", issueWe); end
    tests++; if (busy !== 32'h60) begin fails++; $display("FAIL ind_busy got=%h exp=60", busy); end
    tests++; if ({address1, address2, address3} !== {5'd1, 5'd1, 5'd2, 5'd2, 5'd3, 5'd3})
      begin fails++; $display("FAIL ind_addr got=%h/%h/%h exp=021/042/063", address1, address2, address3); end
    wbValid = 2'b01; wbAddr = {5'd0, 5'd6};
    tick();
    clearIn();
    tests++; if (enable !== 2'b00) begin fails++; $display("FAIL ind_idle_enable got=%b exp=00", enable); end
    tests++; if (busy !== 32'h20) begin fails++; $display("FAIL ind_wb6_busy got=%h exp=20", busy); end
  endtask

  task automatic test_raw_stall();
    bundleValid = 1'b1;
    setSlot(0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    #1;
    tests++; if (bundleReady !== 1'b0) begin fails++; $display("FAIL raw_ready0 got=%b exp=0", bundleReady); end
    tick();
    tests++; if (stalled !== 1'b1) begin fails++; $display("FAIL raw_stalled got=%b exp=1", stalled); end
    tests++; if (stallCount !== 16'd1) begin fails++; $display("FAIL raw_count1 got=%0d exp=1", stallCount); end
    tests++; if (enable !== 2'b00) begin fails++; $display("FAIL raw_enable0 got=%b exp=00", enable); end
    tick();
    tests++; if (stallCount !== 16'd2) begin fails++; $display("FAIL raw_count2 got=%0d exp=2", stallCount); end
    wbValid = 2'b01; wbAddr = {5'd0, 5'd5};
    #1;
    tests++; if (bundleReady !== 1'b0) begin fails++; $display("FAIL raw_ready_wbcycle got=%b exp=0", bundleReady); end
    tick();
    wbValid = 2'b00;
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL raw_busy got=%h exp=0", busy); end
    tests++; if (stallCount !== 16'd3) begin fails++; $display("FAIL raw_count3 got=%0d exp=3", stallCount); end
    #1;
    tests++; if (bundleReady !== 1'b1) begin fails++; $display("FAIL raw_ready1 got=%b exp=1", bundleReady); end
    tick();
    clearIn();
    tests++; if (enable !== 2'b01) begin fails++; $display("FAIL raw_enable got=%b exp=01", enable); end
    tests++; if (address1[4:0] !== 5'd5) begin fails++; $display("FAIL raw_addr1 got=%0d exp=5", address1[4:0]); end
    tests++; if (stalled !== 1'b0) begin fails++; $display("FAIL raw_run got=%b exp=0", stalled); end
    tests++; if (stallCount !== 16'd3) begin fails++; $display("FAIL raw_count_hold got=%0d exp=3", stallCount); end
  endtask

  task automatic test_set_over_clear();
    bundleValid = 1'b1;
    setSlot(0, 1'b1, 1'b1, 5'd7, 5'd1, 5'd2, 5'd3);
    wbValid = 2'b01; wbAddr = {5'd0, 5'd7};
    tick();
    clearIn();
    tests++; if (busy !== 32'h80) begin fails++; $display("FAIL soc_busy got=%h exp=80", busy); end
  endtask

  task automatic test_dup_dest();
    bundleValid = 1'b1;
    setSlot(0, 1'b1, 1'b1, 5'd9, 5'd1, 5'd1, 5'd1);
    setSlot(1, 1'b1, 1'b1, 5'd9, 5'd1, 5'd1, 5'd1);
    #1;
    tests++; if (bundleReady !== 1'b1) begin fails++; $display("FAIL dup_ready got=%b exp=1", bundleReady); end
    tick();
    clearIn();
    tests++; if (bundleError !== 1'b1) begin fails++; $display("FAIL dup_err got=%b exp=1", bundleError); end
    tests++; if (enable !== 2'b00) begin fails++; $display("FAIL dup_enable got=%b exp=00", enable); end
    tests++; if (busy !== 32'h80) begin fails++; $display("FAIL dup_busy got=%h exp=80", busy); end
    wbValid = 2'b01; wbAddr = {5'd0, 5'd3};
    tick();
    tests++; if (bundleError !== 1'b0) begin fails++; $display("FAIL dup_err_pulse got=%b exp=0", bundleError); end
    tests++; if (busy !== 32'h80) begin fails++; $display("FAIL wb_nonbusy got=%h exp=80", busy); end
    wbValid = 2'b10; wbAddr = {5'd7, 5'd0};
    tick();
    clearIn();
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL wb7_busy got=%h exp=0", busy); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 16; k++) begin
      bundleValid = 1'b1;
      setSlot(0, 1'b1, 1'b1, 5'(2*k), 5'(2*k), 5'(2*k), 5'(2*k));
      setSlot(1, 1'b1, 1'b1, 5'(2*k+1), 5'(2*k), 5'(2*k), 5'(2*k));
      tick();
    end
    clearIn();
    tests++; if (busy !== 32'hFFFF_FFFF) begin fails++; $display("FAIL fill_busy got=%h exp=ffffffff", busy); end
    bundleValid = 1'b1;
    setSlot(0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd0, 5'd0);
    tick();
    tests++; if (stalled !== 1'b1) begin fails++; $display("FAIL flush_pre_stall got=%b exp=1", stalled); end
    flush = 1'b1; wbValid = 2'b11; wbAddr = {5'd4, 5'd3};
    #1;
    tests++; if (bundleReady !== 1'b0) begin fails++; $display("FAIL flush_ready got=%b exp=0", bundleReady); end
    tick();
    clearIn();
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL flush_busy got=%h exp=0", busy); end
    tests++; if (stalled !== 1'b0) begin fails++; $display("FAIL flush_run got=%b exp=0", stalled); end
    tests++; if (enable !== 2'b00) begin fails++; $display("FAIL flush_enable got=%b exp=00", enable); end
    tests++; if (stallCount !== 16'd4) begin fails++; $display("FAIL flush_count got=%0d exp=4", stallCount); end
  endtask

  task automatic test_saturation();
    bundleValid = 1'b1;
    setSlot(0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0);
    tick();
    clearIn();
    bundleValid = 1'b1;
    setSlot(0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    repeat (70000) tick();
    tests++; if (stallCount !== 16'hFFFF) begin fails++; $display("FAIL sat_count got=%h exp=ffff", stallCount); end
    tests++; if (stalled !== 1'b1) begin fails++; $display("FAIL sat_stalled got=%b exp=1", stalled); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (stalled !== 1'b0) begin fails++; $display("FAIL ar_stalled got=%b exp=0", stalled); end
    tests++; if (busy !== 32'h0) begin fails++; $display("FAIL ar_busy got=%h exp=0", busy); end
    tests++; if (stallCount !== 16'h0) begin fails++; $display("FAIL ar_count got=%h exp=0", stallCount); end
    tests++; if ({enable, issueWe, issueDest} !== 14'h0) begin fails++; $display("FAIL ar_issue got=%h exp=0", {enable, issueWe, issueDest}); end
    tests++; if ({address1, address2, address3} !== 30'h0) begin fails++; $display("FAIL ar_addr got=%h exp=0", {address1, address2, address3}); end
    tests++; if (bundleReady !== 1'b1) begin fails++; $display("FAIL ar_ready got=%b exp=1", bundleReady); end
    clearIn();
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if ({enable, stalled, bundleError} !== 4'h0) begin fails++; $display("FAIL ar_post got=%h exp=0", {enable, stalled, bundleError}); end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw_stall();
    test_set_over_clear();
    test_dup_dest();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
